// File: rtl/matmul_loop_scheduler_if.sv
// Operation bus between the matmul loop scheduler (master) and the shared
// MAC/memory datapath (slave).
interface matmul_loop_scheduler_if #(
    parameter int WIDTH = 16
);
    logic             op_valid;
    logic             op_ready;
    logic             op_clear;
    logic             op_first;
    logic [WIDTH-1:0] a_addr;
    logic [WIDTH-1:0] b_addr;
    logic [WIDTH-1:0] c_addr;

    modport master (
        output op_valid, op_clear, op_first, a_addr, b_addr, c_addr,
        input  op_ready
    );

    modport slave (
        input  op_valid, op_clear, op_first, a_addr, b_addr, c_addr,
        output op_ready
    );
endinterface

// File: rtl/matmul_loop_scheduler.sv
// Runtime-bounded loop scheduler for C[i][j] += A[i][k] * B[k][j]: zero-fills C, then
// issues one MAC per (i,k,j). Define SCHED_PERF_COUNTERS_EN for perf_cycles/perf_stalls.
module matmul_loop_scheduler #(
    parameter int WIDTH   = 16,
    parameter int LATENCY = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] dim_i,
    input  logic [WIDTH-1:0] dim_k,
    input  logic [WIDTH-1:0] dim_j,
    output logic             busy,
    output logic             done,
    matmul_loop_scheduler_if.master op
`ifdef SCHED_PERF_COUNTERS_EN
    ,
    output logic [31:0]      perf_cycles,
    output logic [31:0]      perf_stalls
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    // LATENCY of 0 or 1 both collapse to a single drain cycle.
    localparam logic [31:0] DRAIN_LAST = (LATENCY > 1) ? 32'(LATENCY - 1) : 32'd0;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] di_q, dk_q, dj_q;
    logic [WIDTH-1:0] i_q, k_q, j_q;
    logic [31:0]      drain_q;
    logic             xfer, last_i, last_k, last_j, drain_last, any_zero;

    assign xfer       = op.op_valid & op.op_ready;
    assign last_i     = (i_q == di_q - WIDTH'(1));
    assign last_k     = (k_q == dk_q - WIDTH'(1));
    assign last_j     = (j_q == dj_q - WIDTH'(1));
    assign drain_last = (drain_q == DRAIN_LAST);
    assign any_zero   = (dim_i == '0) | (dim_k == '0) | (dim_j == '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE:  if (start) state_d = any_zero ? S_DONE : S_CLEAR;
                S_CLEAR: if (xfer && last_i && last_j) state_d = S_RUN;
                S_RUN:   if (xfer && last_i && last_k && last_j) state_d = S_DRAIN;
                S_DRAIN: if (drain_last) state_d = S_DONE;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Indices only move on a transfer, so a stalled op keeps every output steady.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            di_q    <= '0;
            dk_q    <= '0;
            dj_q    <= '0;
            i_q     <= '0;
            k_q     <= '0;
            j_q     <= '0;
            drain_q <= '0;
        end else if (abort) begin
            i_q     <= '0;
            k_q     <= '0;
            j_q     <= '0;
            drain_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        di_q    <= dim_i;
                        dk_q    <= dim_k;
                        dj_q    <= dim_j;
                        i_q     <= '0;
                        k_q     <= '0;
                        j_q     <= '0;
                        drain_q <= '0;
                    end
                end
                S_CLEAR: begin
                    if (xfer) begin
                        if (last_j) begin
                            j_q <= '0;
                            i_q <= last_i ? '0 : i_q + WIDTH'(1);
                        end else begin
                            j_q <= j_q + WIDTH'(1);
                        end
                    end
                end
                S_RUN: begin
                    if (xfer) begin
                        if (last_j) begin
                            j_q <= '0;
                            if (last_k) begin
                                k_q <= '0;
                                i_q <= last_i ? '0 : i_q + WIDTH'(1);
                            end else begin
                                k_q <= k_q + WIDTH'(1);
                            end
                        end else begin
                            j_q <= j_q + WIDTH'(1);
                        end
                    end
                end
                S_DRAIN: drain_q <= drain_q + 32'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_DONE) & ~abort;
        op.op_valid = (state_q == S_CLEAR) | (state_q == S_RUN);
        op.op_clear = (state_q == S_CLEAR);
        op.op_first = (state_q == S_RUN) & (k_q == '0);
        op.a_addr   = i_q * dk_q + k_q;
        op.b_addr   = k_q * dj_q + j_q;
        op.c_addr   = i_q * dj_q + j_q;
    end

`ifdef SCHED_PERF_COUNTERS_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_cycles <= '0;
            perf_stalls <= '0;
        end else if (state_q == S_IDLE && start && !abort) begin
            perf_cycles <= '0;
            perf_stalls <= '0;
        end else begin
            if (busy) perf_cycles <= perf_cycles + 32'd1;
            if (op.op_valid && !op.op_ready) perf_stalls <= perf_stalls + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_matmul_loop_scheduler.sv
// Directed self-checking bench for matmul_loop_scheduler (WIDTH=16, LATENCY=2).
module tb_matmul_loop_scheduler;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] dim_i = '0, dim_k = '0, dim_j = '0;
    logic        busy, done;
`ifdef SCHED_PERF_COUNTERS_EN
    logic [31:0] perf_cycles, perf_stalls;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic        clr;
        logic        first;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] c;
    } op_t;

    op_t exp_ops[$];
    op_t got_ops[$];

    matmul_loop_scheduler_if #(.WIDTH(16)) bus ();

    matmul_loop_scheduler #(.WIDTH(16), .LATENCY(2)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .abort       (abort),
        .dim_i       (dim_i),
        .dim_k       (dim_k),
        .dim_j       (dim_j),
        .busy        (busy),
        .done        (done),
        .op          (bus)
`ifdef SCHED_PERF_COUNTERS_EN
        ,
        .perf_cycles (perf_cycles),
        .perf_stalls (perf_stalls)
`endif
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference op stream from plain nested loops over the requested shape.
    task automatic build_ops(input int di, input int dk, input int dj);
        op_t o;
        exp_ops.delete();
        if (di == 0 || dk == 0 || dj == 0) return;
        for (int i = 0; i < di; i++)
            for (int j = 0; j < dj; j++) begin
                o.clr = 1'b1; o.first = 1'b0;
                o.a = 16'(i * dk); o.b = 16'(j); o.c = 16'(i * dj + j);
                exp_ops.push_back(o);
            end
        for (int i = 0; i < di; i++)
            for (int k = 0; k < dk; k++)
                for (int j = 0; j < dj; j++) begin
                    o.clr = 1'b0; o.first = (k == 0);
                    o.a = 16'(i * dk + k); o.b = 16'(k * dj + j); o.c = 16'(i * dj + j);
                    exp_ops.push_back(o);
                end
    endtask

    // Start a run and follow it to done; ready toggles 0,1,0,1 when toggle is set.
    task automatic apply_stimulus(input int di, input int dk, input int dj,
                                  input bit toggle, input int done_at);
        int  idx;
        int  seen;
        op_t o;
        build_ops(di, dk, dj);
        got_ops.delete();
        dim_i = 16'(di); dim_k = 16'(dk); dim_j = 16'(dj);
        start = 1'b1;
        tick();
        start = 1'b0;
        dim_i = 16'hFFFF; dim_k = 16'hFFFF; dim_j = 16'hFFFF;
        idx = 0;
        seen = 0;
        for (int cyc = 1; cyc <= 200 && seen == 0; cyc++) begin
            bus.op_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            if (idx < exp_ops.size()) begin
                check_output("op_valid", 32'(bus.op_valid), 32'd1);
                check_output("op_clear", 32'(bus.op_clear), 32'(exp_ops[idx].clr));
                check_output("op_first", 32'(bus.op_first), 32'(exp_ops[idx].first));
                check_output("a_addr", 32'(bus.a_addr), 32'(exp_ops[idx].a));
                check_output("b_addr", 32'(bus.b_addr), 32'(exp_ops[idx].b));
                check_output("c_addr", 32'(bus.c_addr), 32'(exp_ops[idx].c));
                if (bus.op_ready) begin
                    o.clr = bus.op_clear; o.first = bus.op_first;
                    o.a = bus.a_addr; o.b = bus.b_addr; o.c = bus.c_addr;
                    got_ops.push_back(o);
                    idx++;
                end
            end else begin
                check_output("tail_valid", 32'(bus.op_valid), 32'd0);
                check_output("tail_busy", 32'(busy), 32'd1);
                if (done) seen = cyc;
            end
            tick();
        end
        bus.op_ready = 1'b1;
        check_output("done_cycle", 32'(seen), 32'(done_at));
        check_output("busy_after", 32'(busy), 32'd0);
        check_output("done_after", 32'(done), 32'd0);
    endtask

    initial begin
        logic done_any;
        bus.op_ready = 1'b1;

        // Reset state while reset_n is held low.
        #2;
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_done", 32'(done), 32'd0);
        check_output("rst_valid", 32'(bus.op_valid), 32'd0);
        check_output("rst_clear", 32'(bus.op_clear), 32'd0);
        check_output("rst_first", 32'(bus.op_first), 32'd0);
        check_output("rst_addr", 32'({bus.a_addr | bus.b_addr | bus.c_addr}), 32'd0);
        @(posedge clock);
        #3 reset_n = 1'b1;
        tick();

        // Case 1: (2,3,2) with ready held high.
        apply_stimulus(2, 3, 2, 1'b0, 19);
        check_output("n_ops", 32'(got_ops.size()), 32'd16);
        if (got_ops.size() == 16) begin
            check_output("mac0_abc", {8'd0, got_ops[4].a[7:0], got_ops[4].b[7:0], got_ops[4].c[7:0]}, 32'h00_00_00_00);
            check_output("mac1_abc", {8'd0, got_ops[5].a[7:0], got_ops[5].b[7:0], got_ops[5].c[7:0]}, 32'h00_00_01_01);
            check_output("mac2_abc", {8'd0, got_ops[6].a[7:0], got_ops[6].b[7:0], got_ops[6].c[7:0]}, 32'h00_01_02_00);
            check_output("mac11_abc", {8'd0, got_ops[15].a[7:0], got_ops[15].b[7:0], got_ops[15].c[7:0]}, 32'h00_05_05_03);
            check_output("clr3_c", 32'(got_ops[3].c), 32'd3);
        end

        // Case 2: same shape, every op stalled once.
        apply_stimulus(2, 3, 2, 1'b1, 35);
        check_output("n_ops_toggle", 32'(got_ops.size()), 32'd16);
`ifdef SCHED_PERF_COUNTERS_EN
        check_output("perf_stalls", perf_stalls, 32'd16);
        check_output("perf_cycles", perf_cycles, 32'd35);
`endif

        // Zero dimension: straight to done, no ops.
        apply_stimulus(2, 0, 2, 1'b0, 1);
        check_output("zero_dim_ops", 32'(got_ops.size()), 32'd0);

        // Abort during RUN after the third MAC.
        dim_i = 16'd2; dim_k = 16'd3; dim_j = 16'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        check_output("pre_abort_valid", 32'(bus.op_valid), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_output("abort_valid", 32'(bus.op_valid), 32'd0);
        check_output("abort_busy", 32'(busy), 32'd0);
        done_any = done;
        for (int c = 0; c < 6; c++) begin
            tick();
            done_any |= done;
        end
        check_output("abort_no_done", 32'(done_any), 32'd0);
        apply_stimulus(1, 1, 1, 1'b0, 5);
        check_output("n_ops_111", 32'(got_ops.size()), 32'd2);

        // Asynchronous reset mid-CLEAR.
        dim_i = 16'd2; dim_k = 16'd3; dim_j = 16'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check_output("pre_rst_c", 32'(bus.c_addr), 32'd1);
        #3 reset_n = 1'b0;
        #1;
        check_output("mid_rst_valid", 32'(bus.op_valid), 32'd0);
        check_output("mid_rst_busy", 32'(busy), 32'd0);
        check_output("mid_rst_clear", 32'(bus.op_clear), 32'd0);
        check_output("mid_rst_addr", 32'({bus.a_addr | bus.b_addr | bus.c_addr}), 32'd0);
        start = 1'b1;
        tick();
        tick();
        check_output("rst_start_ignored", 32'(busy), 32'd0);
        start = 1'b0;
        #3 reset_n = 1'b1;
        tick();
        check_output("post_rst_busy", 32'(busy), 32'd0);
        apply_stimulus(1, 1, 1, 1'b0, 5);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/matmul_loop_scheduler.md
Name: matmul_loop_scheduler

Overview:
- Sequences one generated matmul kernel: C[i][j] += A[i][k] * B[k][j].
- Phase 1 zero-fills C; phase 2 issues one MAC op per (i,k,j) triple to the shared MAC/memory datapath via valid/ready.
- Replaces hard-coded per-kernel loop counters; bounds are runtime inputs latched at start, so one scheduler serves any kernel shape up to WIDTH limits.
- Sits between the top-level control (buttons/host) and the kernel datapath.

Parameters:
- WIDTH, 16, width of bounds, indices and addresses
- LATENCY, 2, datapath cycles from op accept to C write commit; drained before done

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  level-sampled in IDLE only; begins a kernel run
- abort  in  1  synchronous; returns to IDLE from any state, no done pulse
- dim_i  in  WIDTH  rows of A/C, latched on start
- dim_k  in  WIDTH  cols of A / rows of B, latched on start
- dim_j  in  WIDTH  cols of B/C, latched on start
- busy  out  1  high in every state except IDLE
- done  out  1  single-cycle pulse at end of run
- op_valid  out  1  operation presented
- op_ready  in  1  datapath accepts op this cycle
- op_clear  out  1  1 = write zero to C[c_addr]; 0 = MAC
- op_first  out  1  MAC with k==0 (informational)
- a_addr  out  WIDTH  i*dim_k + k
- b_addr  out  WIDTH  k*dim_j + j
- c_addr  out  WIDTH  i*dim_j + j

Behaviour:
- Reset (async, reset_n low): state IDLE; i,k,j, latched dims, drain counter = 0; busy, done, op_valid, op_clear, op_first = 0; addresses = 0.
- States: IDLE, CLEAR, RUN, DRAIN, DONE.
- IDLE: start=1 latches dims and zeroes indices. Any dim = 0 -> DONE directly (no ops). Else -> CLEAR.
- CLEAR: op_valid=1, op_clear=1, k held 0; iterate i outer, j inner. On transfer (op_valid & op_ready), advance; on the last (i=dim_i-1, j=dim_j-1), zero indices and enter RUN.
- RUN: op_valid=1, op_clear=0; order i outer, k middle, j inner. Wrap: j hits dim_j -> j=0, k++; k hits dim_k -> k=0, i++. On the last triple -> DRAIN.
- DRAIN: op_valid=0; count LATENCY cycles -> DONE. LATENCY=0 -> DONE next cycle.
- DONE: done=1 for exactly one cycle -> IDLE.
- Outputs are registered: indices, addresses and op_clear are stable while op_valid=1 and op_ready=0. No combinational path from op_ready to op_valid.
- Transfer with op_ready held high gives one op per cycle, with no bubbles at CLEAR->RUN.
- Address arithmetic: products are truncated to WIDTH bits, unsigned. Addresses may be computed incrementally but must match the formulas every cycle.
- Priority: abort beats every other condition. Abort in DONE suppresses done. start is ignored while busy. dim changes while busy are ignored.
- reset_n low mid-run clears state immediately with no done. Partially written C is left as-is.

Optional Feature:
- SCHED_PERF_COUNTERS_EN.
- Defined: adds outputs perf_cycles (32b) and perf_stalls (32b).
  - Both clear on run start.
  - perf_cycles increments every cycle busy=1.
  - perf_stalls increments when op_valid=1 and op_ready=0.
  - Both hold after done until the next start.
  - Both reset to 0 asynchronously.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- dims (2,3,2), op_ready=1, LATENCY=2, start sampled at edge 0:
  - cycles 1-4: CLEAR ops, c_addr 0,1,2,3.
  - cycles 5-16: 12 MAC ops; first three (a,b,c) = (0,0,0), (0,1,1), (1,2,0); last = (5,5,3).
  - cycles 17-18: DRAIN.
  - cycle 19: done=1; busy=0 from cycle 20.
- Same dims, op_ready toggled 1,0,1,0…: 16 transfers total in identical order; outputs unchanged across every ready=0 cycle; done 2 cycles after the last transfer + 1.
- dim_k=0: no op_valid ever; done pulses the cycle after the DONE transition; busy high 1 cycle.
- abort asserted during RUN after the 3rd MAC: op_valid=0 next cycle, state IDLE, done never pulses; new start with (1,1,1) runs 1 clear + 1 MAC.
- reset_n pulsed low mid-CLEAR, asynchronously between edges: all outputs 0 immediately; start ignored until reset_n high.
- With SCHED_PERF_COUNTERS_EN, case 2: perf_stalls=16, perf_cycles equals busy-cycle count.
